// File: rtl/ttl_74161a_cen.sv
// Cascadable 74LS161A-style 4-bit counter chain.
// Counts on a falling edge of Cen detected on the fast clock.
module ttl_74161a_cen #(
  parameter int BLOCKS = 2
) (
  input  logic                  Clk,
  input  logic                  CLRn,
  input  logic                  Cen,
  input  logic                  LOADn,
  input  logic                  ENP,
  input  logic                  ENT,
  input  logic [4*BLOCKS-1:0]   D,
  output logic [4*BLOCKS-1:0]   Q,
  output logic [BLOCKS-1:0]     RCO
);

  logic                cen_q;
  logic                arm_q;
  logic                evt;
  logic [4*BLOCKS-1:0] q_q;
  logic [4*BLOCKS-1:0] q_d;
  logic [BLOCKS-1:0]   ent_c;
  logic [BLOCKS-1:0]   rco_c;

  // cen_q reads high out of clear; arm_q masks the
  // first edge after release so that reference can't fire.
  assign evt = ~Cen & cen_q & arm_q;

  // Carry chain: each block's ENT is the RCO of the one below.
  always_comb begin
    logic run;
    ent_c = '0;
    rco_c = '0;
    run   = ENT;
    for (int k = 0; k < BLOCKS; k++) begin
      ent_c[k] = run;
      run      = run & (q_q[4*k +: 4] == 4'hF);
      rco_c[k] = run;
    end
  end

  // Next state: load beats count; counting needs ENP and ENT_k.
  always_comb begin
    q_d = q_q;
    if (evt) begin
      if (!LOADn) begin
        q_d = D;
      end else if (ENP) begin
        for (int k = 0; k < BLOCKS; k++) begin
          if (ent_c[k]) begin
            q_d[4*k +: 4] = q_q[4*k +: 4] + 4'd1;
          end
        end
      end
    end
  end

  // Counter, edge detector and post-clear arm flag.
  always_ff @(posedge Clk or negedge CLRn) begin
    if (!CLRn) begin
      q_q   <= '0;
      cen_q <= 1'b1;
      arm_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      cen_q <= Cen;
      arm_q <= 1'b1;
    end
  end

  assign Q   = q_q;
  assign RCO = rco_c;

endmodule

// File: tb/tb_ttl_74161a_cen.sv
// Directed bench for ttl_74161a_cen (BLOCKS=2).
// Expected values are hand-computed constants.
module tb_ttl_74161a_cen;

  logic       Clk;
  logic       CLRn;
  logic       Cen;
  logic       LOADn;
  logic       ENP;
  logic       ENT;
  logic [7:0] D;
  logic [7:0] Q;
  logic [1:0] RCO;

  int n_pass;
  int n_total;

  ttl_74161a_cen #(.BLOCKS(2)) dut (
    .Clk   (Clk),
    .CLRn  (CLRn),
    .Cen   (Cen),
    .LOADn (LOADn),
    .ENP   (ENP),
    .ENT   (ENT),
    .D     (D),
    .Q     (Q),
    .RCO   (RCO)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One Cen high-then-low cycle; Q updated on return.
  task automatic ev();
    @(negedge Clk) Cen = 1'b1;
    @(negedge Clk) Cen = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    logic [7:0] exp_q;
    n_pass  = 0;
    n_total = 0;
    CLRn  = 1'b1;
    Cen   = 1'b0;
    LOADn = 1'b1;
    ENP   = 1'b1;
    ENT   = 1'b1;
    D     = 8'h00;

    // Power-on clear
    #1 CLRn = 1'b0;
    #2;
    chk("rst_q", Q, 8'h00);
    chk("rst_rco", {6'd0, RCO}, 8'h00);
    @(negedge Clk);
    @(negedge Clk) CLRn = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rel_low_q", Q, 8'h00);

    // 20 events, Cen toggled every 4 clocks
    for (int i = 0; i < 20; i++) begin
      exp_q = 8'(i);
      @(negedge Clk) Cen = 1'b1;
      repeat (3) @(negedge Clk);
      @(negedge Clk) Cen = 1'b0;
      #1 chk("cnt_pre", Q, exp_q);
      @(posedge Clk);
      #1 chk("cnt_edge", Q, exp_q + 8'd1);
      repeat (3) @(negedge Clk);
      chk("cnt_hold", Q, exp_q + 8'd1);
    end
    chk("cnt_final", Q, 8'h14);

    // Clear in the middle of a pending count
    LOADn = 1'b0;
    D     = 8'h5A;
    ev();
    LOADn = 1'b1;
    chk("ld_5a", Q, 8'h5A);
    @(negedge Clk) Cen = 1'b1;
    @(negedge Clk) Cen = 1'b0;
    #2 CLRn = 1'b0;
    #1 chk("mid_clr_q", Q, 8'h00);
    chk("mid_clr_rco", {6'd0, RCO}, 8'h00);
    @(posedge Clk);
    #1 chk("clr_held", Q, 8'h00);
    @(negedge Clk);
    // Release together with Cen low: no count
    @(negedge Clk) CLRn = 1'b1;
    repeat (4) @(negedge Clk);
    chk("rel_fall_q", Q, 8'h00);

    // Carry and full-chain wrap
    LOADn = 1'b0;
    D     = 8'hFE;
    ev();
    LOADn = 1'b1;
    chk("ld_fe", Q, 8'hFE);
    chk("fe_rco", {6'd0, RCO}, 8'h00);
    ev();
    chk("ff_q", Q, 8'hFF);
    chk("ff_rco", {6'd0, RCO}, 8'h03);
    ev();
    chk("wrap_q", Q, 8'h00);
    chk("wrap_rco", {6'd0, RCO}, 8'h00);

    // Enables
    LOADn = 1'b0;
    D     = 8'h0F;
    ev();
    LOADn = 1'b1;
    ENP   = 1'b0;
    #1 chk("enp0_rco", {6'd0, RCO}, 8'h01);
    repeat (3) ev();
    chk("enp0_hold", Q, 8'h0F);
    ENT = 1'b0;
    #1 chk("ent0_rco", {6'd0, RCO}, 8'h00);
    ENP = 1'b1;
    ev();
    chk("ent0_hold", Q, 8'h0F);

    // Load priority
    ENT   = 1'b1;
    LOADn = 1'b0;
    D     = 8'h33;
    ev();
    chk("ld_33", Q, 8'h33);
    ENP = 1'b0;
    ENT = 1'b0;
    D   = 8'hC7;
    ev();
    chk("ld_c7", Q, 8'hC7);
    D = 8'h11;
    repeat (4) @(negedge Clk);
    chk("ld_static_lo", Q, 8'hC7);
    Cen = 1'b1;
    repeat (4) @(negedge Clk);
    chk("ld_static_hi", Q, 8'hC7);

    // Short pulses
    LOADn = 1'b1;
    ENP   = 1'b1;
    ENT   = 1'b1;
    @(negedge Clk);
    #1 Cen = 1'b0;
    #2 Cen = 1'b1;
    repeat (3) @(negedge Clk);
    chk("glitch", Q, 8'hC7);
    @(negedge Clk) Cen = 1'b0;
    @(negedge Clk) Cen = 1'b1;
    repeat (2) @(negedge Clk);
    chk("one_edge", Q, 8'hC8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
